// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's memory-read port, decode handshake and enable.
// The master modport is the fetch unit; slave is the memory/decode side.
interface fetch_unit_if;
  logic        enable;
  logic [18:0] MMemory_addr;
  logic        MMemory_rd;
  logic [31:0] MMemory_data;
  logic        MMemory_ready;
  logic [31:0] instr;
  logic [18:0] PC;
  logic        run;
  logic        ok;
  logic        redirect;
  logic [18:0] redirect_PC;
  logic [31:0] icount;

  modport master (
    input  enable, MMemory_data, MMemory_ready, ok, redirect, redirect_PC,
    output MMemory_addr, MMemory_rd, instr, PC, run, icount
  );

  modport slave (
    output enable, MMemory_data, MMemory_ready, ok, redirect, redirect_PC,
    input  MMemory_addr, MMemory_rd, instr, PC, run, icount
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads one word from main memory, hands it to
// decode, then advances (or redirects) the PC once decode reports done.
module fetch_unit #(
  parameter logic [18:0] RESET_PC = 19'h00000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [18:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] icount_reg, icount_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      instr_reg  <= 32'h0;
      icount_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      icount_reg <= icount_next;
    end
  end

  // ok/redirect/ready only matter in the state that consumes them, so
  // stray pulses elsewhere fall through to the hold defaults.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    icount_next = icount_reg;
    case (state_reg)
      IDLE: begin
        if (bus.enable) state_next = MEM_REQ;
      end
      MEM_REQ: begin
        if (bus.MMemory_ready) begin
          instr_next = bus.MMemory_data;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ok) begin
          pc_next     = bus.redirect ? bus.redirect_PC : pc_reg + 19'd1;
          icount_next = icount_reg + 32'd1;
          state_next  = bus.enable ? MEM_REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The fetch address and the presented PC are the same register: it only
  // changes on the ISSUE->next transition, so it is stable throughout MEM_REQ.
  assign bus.MMemory_addr = pc_reg;
  assign bus.MMemory_rd   = (state_reg == MEM_REQ);
  assign bus.run          = (state_reg == ISSUE);
  assign bus.PC           = pc_reg;
  assign bus.instr        = instr_reg;
  assign bus.icount       = icount_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// enable/reset sequences, then randomized transactions against a PC model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(19'h00000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_icount;
  logic [18:0] model_pc;

  typedef struct {
    int          rdly;
    logic [31:0] data;
    int          okdly;
    logic        redir;
    logic [18:0] rpc;
    logic        en;
    logic [18:0] exp_pc;
    logic [18:0] exp_next;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for a read request at exp_pc, answers after rdly stall cycles.
  task automatic do_fetch(input int rdly, input logic [31:0] data, input logic [18:0] exp_pc);
    int waited = 0;
    logic [18:0] addr0;
    bus.MMemory_ready = 1'b0;
    while (bus.MMemory_rd !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", bus.MMemory_rd, 1'b1);
    chk("req_addr", bus.MMemory_addr, exp_pc);
    addr0 = bus.MMemory_addr;
    for (int k = 0; k < rdly; k++) begin
      bus.MMemory_ready = 1'b0;
      bus.ok            = 1'($urandom_range(0, 1));
      bus.redirect      = 1'b1;
      bus.redirect_PC   = 19'($urandom);
      @(negedge clk);
      chk("req_hold", {bus.MMemory_rd, bus.run, bus.MMemory_addr}, {1'b1, 1'b0, addr0});
    end
    bus.MMemory_ready = 1'b1;
    bus.MMemory_data  = data;
    @(negedge clk);
    bus.MMemory_ready = 1'b0;
    bus.MMemory_data  = $urandom;
    bus.ok            = 1'b0;
    bus.redirect      = 1'b0;
    chk("issue_run", {bus.run, bus.MMemory_rd}, 2'b10);
    chk("issue_instr", bus.instr, data);
    chk("issue_pc", bus.PC, exp_pc);
    $display("[TB] fetch pc=%05h data=%08h stall=%0d", exp_pc, data, rdly);
  endtask

  // Holds ok low for okdly cycles (with junk on ignored inputs), then accepts.
  task automatic accept(input int okdly, input logic redir, input logic [18:0] rpc,
                        input logic en, input logic [18:0] exp_pc,
                        input logic [31:0] data, input logic [18:0] exp_next);
    for (int k = 0; k < okdly; k++) begin
      bus.ok            = 1'b0;
      bus.redirect      = 1'($urandom_range(0, 1));
      bus.redirect_PC   = 19'($urandom);
      bus.MMemory_ready = 1'($urandom_range(0, 1));
      bus.MMemory_data  = $urandom;
      @(negedge clk);
      chk("issue_hold", {bus.run, bus.MMemory_rd, bus.PC, bus.instr},
          {1'b1, 1'b0, exp_pc, data});
    end
    bus.ok            = 1'b1;
    bus.redirect      = redir;
    bus.redirect_PC   = rpc;
    bus.enable        = en;
    bus.MMemory_ready = 1'b0;
    @(negedge clk);
    bus.ok       = 1'b0;
    bus.redirect = 1'b0;
    model_icount = model_icount + 32'd1;
    chk("icount", bus.icount, model_icount);
    chk("after_ok_state", {bus.MMemory_rd, bus.run}, {en, 1'b0});
    chk("next_addr", bus.MMemory_addr, exp_next);
    $display("[TB] accept pc=%05h redirect=%0d next=%05h en=%0d icount=%0d",
             exp_pc, redir, exp_next, en, model_icount);
  endtask

  task automatic idle_check(input int cycles, input logic [18:0] exp_pc, input logic [31:0] exp_instr);
    for (int k = 0; k < cycles; k++) begin
      bus.ok            = 1'b1;
      bus.redirect      = 1'b1;
      bus.redirect_PC   = 19'($urandom);
      bus.MMemory_ready = 1'b1;
      bus.MMemory_data  = $urandom;
      @(negedge clk);
      chk("idle_hold", {bus.MMemory_rd, bus.run, bus.MMemory_addr, bus.instr},
          {1'b0, 1'b0, exp_pc, exp_instr});
      chk("idle_icount", bus.icount, model_icount);
    end
    bus.ok            = 1'b0;
    bus.redirect      = 1'b0;
    bus.MMemory_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [18:0] rpc, nxt;
    logic        redir, en;
    int          rdly, okdly;

    vecs[0] = '{1, 32'h2008_0005, 1, 1'b0, 19'h00000, 1'b1, 19'h00000, 19'h00001};
    vecs[1] = '{0, 32'hA5A5_0001, 0, 1'b1, 19'h00010, 1'b1, 19'h00001, 19'h00010};
    vecs[2] = '{3, 32'h1234_5678, 0, 1'b1, 19'h00400, 1'b1, 19'h00010, 19'h00400};
    vecs[3] = '{0, 32'hDEAD_BEEF, 2, 1'b1, 19'h00010, 1'b1, 19'h00400, 19'h00010};
    vecs[4] = '{1, 32'h0BAD_F00D, 0, 1'b0, 19'h00000, 1'b1, 19'h00010, 19'h00011};
    vecs[5] = '{0, 32'h5555_AAAA, 0, 1'b1, 19'h7FFFF, 1'b1, 19'h00011, 19'h7FFFF};
    vecs[6] = '{2, 32'hCAFE_0006, 1, 1'b0, 19'h00000, 1'b1, 19'h7FFFF, 19'h00000};
    vecs[7] = '{0, 32'h0000_0007, 0, 1'b0, 19'h00000, 1'b0, 19'h00000, 19'h00001};

    rst_n             = 1'b0;
    bus.enable        = 1'b0;
    bus.ok            = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_PC   = 19'h0;
    bus.MMemory_ready = 1'b0;
    bus.MMemory_data  = 32'h0;
    model_icount      = 32'h0;
    #12;
    chk("reset_outputs", {bus.MMemory_rd, bus.run, bus.MMemory_addr, bus.PC},
        {1'b0, 1'b0, 19'h0, 19'h0});
    chk("reset_instr", bus.instr, 32'h0);
    chk("reset_icount", bus.icount, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.enable = 1'b1;

    // Directed vector table: redirect, stalls, wrap, final stop to IDLE.
    for (int i = 0; i < 8; i++) begin
      do_fetch(vecs[i].rdly, vecs[i].data, vecs[i].exp_pc);
      accept(vecs[i].okdly, vecs[i].redir, vecs[i].rpc, vecs[i].en,
             vecs[i].exp_pc, vecs[i].data, vecs[i].exp_next);
    end
    idle_check(4, 19'h00001, vecs[7].data);

    // Enable dropped while the read is outstanding.
    bus.enable = 1'b1;
    @(negedge clk);
    chk("resume_req", bus.MMemory_rd, 1'b1);
    bus.enable = 1'b0;
    do_fetch(2, 32'h1111_2222, 19'h00001);
    accept(0, 1'b0, 19'h0, 1'b0, 19'h00001, 32'h1111_2222, 19'h00002);
    idle_check(2, 19'h00002, 32'h1111_2222);
    bus.enable = 1'b1;
    do_fetch(0, 32'h3333_4444, 19'h00002);

    // Reset while run=1 at PC 5, with a stale ready across reset release.
    accept(0, 1'b1, 19'h00005, 1'b1, 19'h00002, 32'h3333_4444, 19'h00005);
    do_fetch(1, 32'h5555_6666, 19'h00005);
    #2;
    rst_n             = 1'b0;
    bus.enable        = 1'b0;
    bus.MMemory_ready = 1'b1;
    bus.MMemory_data  = 32'hFFFF_0000;
    #1;
    chk("async_reset_run", {bus.run, bus.MMemory_rd, bus.PC, bus.MMemory_addr},
        {1'b0, 1'b0, 19'h0, 19'h0});
    chk("async_reset_regs", {bus.instr, bus.icount}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("stale_ready", {bus.run, bus.MMemory_rd, bus.instr}, {1'b0, 1'b0, 32'h0});
    bus.MMemory_ready = 1'b0;
    bus.enable        = 1'b1;
    model_icount      = 32'h0;
    do_fetch(0, 32'h7777_8888, 19'h00000);
    accept(0, 1'b0, 19'h0, 1'b1, 19'h00000, 32'h7777_8888, 19'h00001);

    // Randomized transactions against the PC/icount model.
    model_pc = 19'h00001;
    for (int t = 0; t < 150; t++) begin
      rdly  = $urandom_range(0, 3);
      okdly = $urandom_range(0, 2);
      d     = $urandom;
      redir = ($urandom_range(0, 3) == 0);
      rpc   = ($urandom_range(0, 5) == 0) ? 19'h7FFFF : 19'($urandom);
      en    = ($urandom_range(0, 4) != 0);
      nxt   = redir ? rpc : 19'((32'(model_pc) + 32'd1) % 32'h80000);
      do_fetch(rdly, d, model_pc);
      accept(okdly, redir, rpc, en, model_pc, d, nxt);
      model_pc = nxt;
      if (!en) begin
        idle_check($urandom_range(0, 3), model_pc, d);
        bus.enable = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
